// File: rtl/led_pwm_fader_if.sv
// LED pattern in, PWM drive and fade-busy flag out.
// The fader is the slave; whatever supplies the pattern is the master.
interface led_pwm_fader_if;
    logic [3:0] led_in;
    logic [3:0] led_pwm;
    logic       busy;

    modport master (
        output led_in,
        input  led_pwm,
        input  busy
    );

    modport slave (
        input  led_in,
        output led_pwm,
        output busy
    );
endinterface

// File: rtl/led_pwm_fader.sv
// LED PWM fader: four channels fade linearly between 0 and MAX whenever
// the incoming pattern bit changes. Shared PWM counter and ramp divider,
// one level register per channel.

// Per-channel level register, saturating ramp and PWM comparator.
module led_pwm_fader_ch #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_tick,
    input  logic                i_led,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic [PWM_BITS-1:0] o_level,
    output logic                o_pwm,
    output logic                o_mismatch
);
    localparam logic [PWM_BITS-1:0] MAX_L  = '1;
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);

    // Fade state is a pure function of level and target; nothing extra
    // is stored, so a target flip mid-fade reverses from the current level.
    typedef enum logic [1:0] {
        CH_OFF,
        CH_RISING,
        CH_ON,
        CH_FALLING
    } ch_state_e;

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_tgt;
    logic [PWM_BITS:0]   w_sum;
    logic [PWM_BITS:0]   w_dif;
    logic [PWM_BITS-1:0] w_up;
    logic [PWM_BITS-1:0] w_dn;
    ch_state_e           w_state;

    assign w_tgt = i_led ? MAX_L : '0;

    // One extra bit so the ramp saturates instead of wrapping.
    assign w_sum = {1'b0, r_level} + STEP_W;
    assign w_dif = {1'b0, r_level} - STEP_W;
    assign w_up  = (w_sum > {1'b0, MAX_L}) ? MAX_L : w_sum[PWM_BITS-1:0];
    assign w_dn  = w_dif[PWM_BITS] ? '0 : w_dif[PWM_BITS-1:0];

    // Derive the fade state from level vs. target.
    always_comb begin
        w_state = CH_OFF;
        if (r_level < w_tgt)
            w_state = CH_RISING;
        else if (r_level > w_tgt)
            w_state = CH_FALLING;
        else if (i_led)
            w_state = CH_ON;
    end

    assign o_mismatch = (r_level != w_tgt);
    assign o_level    = r_level;

    // Level moves only on a ramp tick; PWM output follows the level the
    // cycle after it is written, with no period alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
            o_pwm   <= 1'b0;
        end else begin
            o_pwm <= (i_pwm_cnt < r_level);
            if (i_tick) begin
                case (w_state)
                    CH_RISING:  r_level <= w_up;
                    CH_FALLING: r_level <= w_dn;
                    default:    r_level <= r_level;
                endcase
            end
        end
    end
endmodule

// Top: input register, shared counters, channel array, busy flag.
module led_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 256,
    parameter int STEP     = 1
) (
    input  logic            clk,
    input  logic            rst,
    led_pwm_fader_if.slave  io_bus
);
    localparam int                  NUM_CH = 4;
    localparam int                  DIV_W  = $clog2(RAMP_DIV);
    localparam logic [PWM_BITS-1:0] MAX_L  = '1;
    localparam logic [DIV_W-1:0]    DIV_TOP = DIV_W'(RAMP_DIV - 1);

    logic [NUM_CH-1:0]                r_led_q;
    logic [PWM_BITS-1:0]              r_pwm_cnt;
    logic [DIV_W-1:0]                 r_div_cnt;
    logic                             r_busy;
    logic                             w_tick;
    logic [NUM_CH-1:0][PWM_BITS-1:0]  w_level;
    logic [NUM_CH-1:0]                w_pwm;
    logic [NUM_CH-1:0]                w_mismatch;

    assign w_tick = (r_div_cnt == DIV_TOP);

    // Pattern register; same clock domain as the source, so no synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_led_q <= '0;
        else
            r_led_q <= io_bus.led_in;
    end

    // PWM counter runs 0..MAX-1 so level MAX is a constant-on output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pwm_cnt <= '0;
        else if (r_pwm_cnt == MAX_L - PWM_BITS'(1))
            r_pwm_cnt <= '0;
        else
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end

    // Ramp divider: one tick every RAMP_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_div_cnt <= '0;
        else if (w_tick)
            r_div_cnt <= '0;
        else
            r_div_cnt <= r_div_cnt + DIV_W'(1);
    end

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        led_pwm_fader_ch #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_tick     (w_tick),
            .i_led      (r_led_q[g]),
            .i_pwm_cnt  (r_pwm_cnt),
            .o_level    (w_level[g]),
            .o_pwm      (w_pwm[g]),
            .o_mismatch (w_mismatch[g])
        );
    end

    // Busy: any channel still away from its target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= 1'b0;
        else
            r_busy <= |w_mismatch;
    end

    assign io_bus.led_pwm = w_pwm;
    assign io_bus.busy    = r_busy;
endmodule
